// File: rtl/if_fetch_ctrl_if.sv
// Fetch-controller bus bundle: hazard/redirect inputs, ROM port and IF/ID outputs.
// The master modport is the fetch controller; the slave modport is the surrounding pipeline and ROM.
interface if_fetch_ctrl_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] im_addr_o;
  logic [31:0] im_inst_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_inst_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic        halted_o;
  logic        fault_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, im_inst_i,
    output im_addr_o, if_id_valid_o, if_id_inst_o, if_id_pc_o, if_id_pc4_o,
           halted_o, fault_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, im_inst_i,
    input  im_addr_o, if_id_valid_o, if_id_inst_o, if_id_pc_o, if_id_pc4_o,
           halted_o, fault_o
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills IF/ID, handles stall/redirect/halt/fault.
// Optional macro IF_PERF_CNT_EN adds RUN-cycle and stall-cycle counters.
module if_fetch_ctrl #(
  parameter logic [31:0] PC_BASE   = 32'h0000_3000,
  parameter int unsigned IM_WORDS  = 1024,
  parameter logic [31:0] HALT_INST = 32'h0000_000C
) (
  input  logic           clk,
  input  logic           rst_n,
  if_fetch_ctrl_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]    cyc_cnt_o,
  output logic [31:0]    stall_cnt_o
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_e;

  localparam logic [31:0] WIN_BYTES = 32'(4 * IM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        halted_q, fault_q;
  logic        bubble;
  logic [31:0] pc_plus4;

  // Unsigned offset compare also rejects addresses below the base after wrap.
  function automatic logic in_window(input logic [31:0] addr);
    return (addr - PC_BASE) < WIN_BYTES;
  endfunction

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    pc4_d   = pc4_q;
    bubble  = 1'b0;
    case (state_q)
      BOOT: begin
        bubble  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (bus.redirect_i) begin
          bubble = 1'b1;
          if ((bus.redirect_pc_i[1:0] != 2'b00) || !in_window(bus.redirect_pc_i)) begin
            state_d = FAULT;
          end else begin
            pc_d = bus.redirect_pc_i;
          end
        end else if (!bus.stall_i) begin
          if (!in_window(pc_q)) begin
            state_d = FAULT;
            bubble  = 1'b1;
          end else begin
            valid_d = 1'b1;
            inst_d  = bus.im_inst_i;
            ipc_d   = pc_q;
            pc4_d   = pc_plus4;
            pc_d    = pc_plus4;
            if (bus.im_inst_i == HALT_INST) begin
              state_d = HALT;
            end
          end
        end
      end
      HALT: begin
        bubble = !bus.stall_i;
      end
      FAULT: begin
        bubble = 1'b1;
      end
      default: begin
        state_d = FAULT;
        bubble  = 1'b1;
      end
    endcase
    if (bubble) begin
      valid_d = 1'b0;
      inst_d  = '0;
      ipc_d   = '0;
      pc4_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= PC_BASE;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
      pc4_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      pc4_q    <= pc4_d;
      halted_q <= (state_d == HALT);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign bus.im_addr_o     = pc_q;
  assign bus.if_id_valid_o = valid_q;
  assign bus.if_id_inst_o  = inst_q;
  assign bus.if_id_pc_o    = ipc_q;
  assign bus.if_id_pc4_o   = pc4_q;
  assign bus.halted_o      = halted_q;
  assign bus.fault_o       = fault_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] cyc_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q       <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == RUN) begin
      cyc_q <= cyc_q + 32'd1;
      if (bus.stall_i && !bus.redirect_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign cyc_cnt_o   = cyc_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 5-stage pipeline without forwarding; owns the PC and drives the address of the 4 KB instruction ROM.
- Registers the returned word into the IF/ID pipeline register.
- Applies stalls from the hazard unit and redirects from ID-stage branch/jump resolution.
- Stops fetch on a halt instruction or on an illegal fetch address.

Parameters:
- PC_BASE, 32'h0000_3000: reset PC and base of the fetch window.
- IM_WORDS, 1024: ROM depth in words; the fetch window is [PC_BASE, PC_BASE + 4*IM_WORDS).
- HALT_INST, 32'h0000_000C: instruction encoding that halts fetch (syscall).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC and IF/ID (load-use / RAW hazard).
- redirect_i  in  1  branch taken or jump resolved in ID.
- redirect_pc_i  in  32  target PC for a redirect.
- im_addr_o  out  32  byte address to the instruction ROM; the ROM uses bits [11:2].
- im_inst_i  in  32  combinational ROM data for im_addr_o.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_inst_o  out  32  IF/ID instruction.
- if_id_pc_o  out  32  PC of the IF/ID instruction.
- if_id_pc4_o  out  32  PC+4 of the IF/ID instruction.
- halted_o  out  1  controller is in HALT.
- fault_o  out  1  controller is in FAULT.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = PC_BASE, state = BOOT.
  - if_id_valid_o = 0; if_id_inst_o, if_id_pc_o and if_id_pc4_o = 0.
  - halted_o = 0, fault_o = 0.
  - Reset asserted mid-operation discards everything in flight.
- im_addr_o = pc, combinational from the PC register. ROM read latency is 0, so im_inst_i is sampled in the same cycle.
- Bubble = valid 0, inst 32'h0 (nop), pc and pc4 fields 0.
- States: BOOT, RUN, HALT, FAULT.
- BOOT: lasts exactly one cycle. No fetch; IF/ID gets a bubble. Then RUN.
- RUN, priority redirect > stall > advance, evaluated each cycle:
  - redirect_i = 1: stall_i is ignored and IF/ID gets a bubble (squash wrong-path fetch).
    - If redirect_pc_i[1:0] != 0 or it lies outside the window: go to FAULT, pc holds.
    - Otherwise pc <= redirect_pc_i.
  - stall_i = 1 (no redirect): pc and all IF/ID fields hold.
  - Advance, in this order:
    - If pc lies outside the window: go to FAULT and IF/ID gets a bubble.
    - Otherwise IF/ID <= {1, im_inst_i, pc, pc+4} and pc <= pc+4.
    - If im_inst_i == HALT_INST, the instruction is still registered into IF/ID, then go to HALT with pc held at the halt address + 4.
- Window check: (pc - PC_BASE) < 4*IM_WORDS, unsigned 32-bit. PC arithmetic is modulo 2^32, so wrap-around is caught by the window check on the next fetch.
- HALT:
  - No fetch; redirect_i is ignored.
  - stall_i = 1 holds IF/ID; otherwise IF/ID gets a bubble. This lets the halt instruction drain.
  - halted_o = 1.
- FAULT:
  - No fetch; IF/ID is a bubble; redirect and stall are ignored.
  - fault_o = 1.
- Only reset exits HALT or FAULT.
- halted_o and fault_o are registered state decodes and are valid the cycle after the transition.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds two outputs:
  - cyc_cnt_o (32): counts cycles spent in RUN.
  - stall_cnt_o (32): counts RUN cycles with stall_i = 1 and redirect_i = 0.
- Both counters reset to 0, wrap modulo 2^32, and freeze in HALT and FAULT.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ROM with words 0..3 = A, B, C, D and no stall -> BOOT cycle shows a bubble. IF/ID then shows A@0x3000, B@0x3004, C@0x3008 on successive cycles, with if_id_pc4_o = pc + 4.
- stall_i high for 2 cycles while B is in IF/ID -> IF/ID stays B@0x3004 and im_addr_o stays 0x3008 for both cycles. C follows on release.
- redirect_i with redirect_pc_i = 0x3010 and stall_i high in the same cycle -> next IF/ID is a bubble. Then the word at 0x3010 is fetched; the stall is ignored.
- redirect_pc_i = 0x3002, then separately 0x4000 -> fault_o = 1 the next cycle and IF/ID bubbles forever. rst_n low clears fault_o asynchronously.
- Word at 0x300C = 0x0000000C -> it appears in IF/ID with valid = 1, halted_o rises the next cycle, and subsequent IF/ID entries are bubbles. A later redirect has no effect.
- Straight-line code to the end of the ROM (pc = 0x3FFC, then 0x4000) -> the last word is fetched and FAULT is entered on 0x4000. With IF_PERF_CNT_EN defined, cyc_cnt_o equals the count of RUN cycles and stall_cnt_o equals the number of injected stall cycles.
